// File: rtl/spi_rx_framer.sv
// -----------------------------------------------------------------------------
// spi_rx_framer
//
// SPI-slave receive framer. spi_clk, spi_mosi and spi_cs are oversampled in the
// axi_aclk domain through synchronisers. DATA_W-bit words are assembled MSB
// first in any of the four SPI modes and buffered in a first-word-fall-through
// FIFO. Each packet (a cs-low window) produces one start pulse and one end
// pulse, and its word count is latched into package_len.
//
// Parameters
//   DATA_W       bits per word (4..32)
//   FIFO_DEPTH   FIFO entries, power of two (4..256)
//   SPI_MODE     CPOL/CPHA mode 0..3 (0,3 sample rising, 1,2 sample falling)
//   SYNC_STAGES  synchroniser depth on each SPI input (2..4)
//
// Ports
//   axi_aclk           sole clock
//   axi_areset         asynchronous active-high reset
//   spi_clk/mosi/cs    raw SPI pins (cs active low)
//   rd_en              pop the head word (ignored while fifo_empty)
//   rd_data            head word, valid while !fifo_empty
//   fifo_empty/full    FIFO status
//   fifo_level         occupancy, 0..FIFO_DEPTH
//   overflow           sticky drop flag, cleared by overflow_clr (drop wins)
//   package_start_int  one-cycle pulse on packet start
//   package_end_int    one-cycle pulse on packet end
//   package_len        words of the last packet incl. dropped, saturating
//
// Build option
//   SPI_RX_PARTIAL_FLUSH_EN  when defined, a partial word left at cs rise is
//                            pushed left-aligned with zero-padded LSBs;
//                            otherwise it is discarded and not counted.
// -----------------------------------------------------------------------------
module spi_rx_framer #(
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int SPI_MODE    = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          axi_aclk,
  input  logic                          axi_areset,
  input  logic                          spi_clk,
  input  logic                          spi_mosi,
  input  logic                          spi_cs,
  input  logic                          rd_en,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          overflow_clr,
  output logic                          package_start_int,
  output logic                          package_end_int,
  output logic [15:0]                   package_len
);

  localparam int   PTR_W       = $clog2(FIFO_DEPTH);
  localparam int   BC_W        = $clog2(DATA_W + 1);
  localparam int   ST_W        = $clog2(SYNC_STAGES + 1);
  localparam logic CPOL        = (SPI_MODE >= 2);
  localparam logic SAMPLE_RISE = (SPI_MODE == 0) || (SPI_MODE == 3);

  typedef enum logic [1:0] {
    WAIT_HIGH,
    IDLE,
    ACTIVE
  } state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // Input synchronisers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_prev_q;
  logic                   cs_s;
  logic                   sclk_s;
  logic                   mosi_s;

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s = clk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      cs_sync_q   <= {SYNC_STAGES{1'b1}};
      clk_sync_q  <= {SYNC_STAGES{CPOL}};
      mosi_sync_q <= '0;
      sclk_prev_q <= CPOL;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], spi_clk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev_q <= sclk_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Framer state
  // ---------------------------------------------------------------------------
  state_t              state_q;
  logic [ST_W-1:0]     settle_q;
  logic [DATA_W-2:0]   shift_q;      // previously received bits of the word
  logic [BC_W-1:0]     bit_cnt_q;
  logic [15:0]         word_cnt_q;
  logic                start_q;
  logic                end_q;
  logic [15:0]         len_q;
  logic                push_q;
  logic [DATA_W-1:0]   push_data_q;

  logic                sample_edge;
  logic [DATA_W-1:0]   word_d;
  logic [DATA_W-2:0]   shift_d;
  logic [BC_W-1:0]     bit_cnt_d;
  logic                word_done;
  logic [15:0]         word_cnt_d;

  // Effect of this cycle's sampling edge. Evaluated before the cs-rise
  // handling so an edge coinciding with cs rise can still finish a word.
  always_comb begin
    sample_edge = SAMPLE_RISE ? (sclk_s & ~sclk_prev_q) : (~sclk_s & sclk_prev_q);
    word_d      = {1'b0, shift_q};
    bit_cnt_d   = bit_cnt_q;
    word_done   = 1'b0;
    word_cnt_d  = word_cnt_q;
    if (state_q == ACTIVE && sample_edge) begin
      word_d = {shift_q, mosi_s};
      if (bit_cnt_q == BC_W'(DATA_W - 1)) begin
        bit_cnt_d  = '0;
        word_done  = 1'b1;
        word_cnt_d = sat_inc(word_cnt_q);
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
    shift_d = word_d[DATA_W-2:0];
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state_q     <= WAIT_HIGH;
      settle_q    <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
      start_q     <= 1'b0;
      end_q       <= 1'b0;
      len_q       <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      start_q <= 1'b0;
      end_q   <= 1'b0;
      push_q  <= 1'b0;
      case (state_q)
        // The synchroniser reset value of cs is 1, which says nothing about
        // the pin. Wait until the chain has been refilled from the pin before
        // trusting a high cs, so a packet in flight at reset release is skipped.
        WAIT_HIGH: begin
          if (settle_q != ST_W'(SYNC_STAGES)) begin
            settle_q <= settle_q + 1'b1;
          end else if (cs_s) begin
            state_q <= IDLE;
          end
        end
        IDLE: begin
          if (!cs_s) begin
            state_q    <= ACTIVE;
            start_q    <= 1'b1;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
          end
        end
        ACTIVE: begin
          shift_q     <= shift_d;
          bit_cnt_q   <= bit_cnt_d;
          word_cnt_q  <= word_cnt_d;
          push_q      <= word_done;
          push_data_q <= word_d;
          if (cs_s) begin
            state_q <= IDLE;
            end_q   <= 1'b1;
            len_q   <= word_cnt_d;
`ifdef SPI_RX_PARTIAL_FLUSH_EN
            if (bit_cnt_d != '0) begin
              // Received bits sit in the low bit_cnt_d positions; move them
              // to the MSBs, zero-filling the LSBs.
              push_q      <= 1'b1;
              push_data_q <= word_d << (BC_W'(DATA_W) - bit_cnt_d);
              len_q       <= sat_inc(word_cnt_d);
            end
`endif
          end
        end
        default: state_q <= WAIT_HIGH;
      endcase
    end
  end

  assign package_start_int = start_q;
  assign package_end_int   = end_q;
  assign package_len       = len_q;

  // ---------------------------------------------------------------------------
  // FWFT FIFO with wrap-extended pointers
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr_q;
  logic [PTR_W:0]    rd_ptr_q;
  logic [PTR_W:0]    wr_ptr_d;
  logic [PTR_W:0]    rd_ptr_d;
  logic [PTR_W:0]    level;
  logic [PTR_W:0]    level_after_pop;
  logic              do_pop;
  logic              do_push;
  logic              drop;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;
  logic              overflow_q;

  always_comb begin
    level           = wr_ptr_q - rd_ptr_q;
    do_pop          = rd_en && (level != '0);
    // A full FIFO still accepts a push when a pop frees the slot this cycle.
    do_push         = push_q && ((level != (PTR_W+1)'(FIFO_DEPTH)) || do_pop);
    drop            = push_q && !do_push;
    wr_ptr_d        = wr_ptr_q + {{PTR_W{1'b0}}, do_push};
    rd_ptr_d        = rd_ptr_q + {{PTR_W{1'b0}}, do_pop};
    level_after_pop = level - {{PTR_W{1'b0}}, do_pop};
    // Registered head word: if nothing older remains after the pop, the head
    // is the word being written now (or nothing); otherwise it is in memory.
    if (level_after_pop == '0) begin
      rd_data_d = do_push ? push_data_q : '0;
    end else begin
      rd_data_d = mem[rd_ptr_d[PTR_W-1:0]];
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (do_push) begin
      mem[wr_ptr_q[PTR_W-1:0]] <= push_data_q;
    end
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_data_q <= rd_data_d;
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (overflow_clr) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign rd_data    = rd_data_q;
  assign fifo_level = level;
  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == (PTR_W+1)'(FIFO_DEPTH));
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_spi_rx_framer.sv
`timescale 1ns/1ps
module tb_spi_rx_framer;

  localparam int S = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Shared SPI bus: 'lead' is the raw clock phase (0 idle, 1 after leading edge)
  logic cs   = 1'b1;
  logic mosi = 1'b0;
  logic lead = 1'b0;

  // Main DUT: DATA_W=8, FIFO_DEPTH=4, mode 0
  logic        rd_en_a   = 1'b0;
  logic        ovf_clr_a = 1'b0;
  logic [7:0]  rd_data_a;
  logic        empty_a, full_a, ovf_a, start_a, end_a;
  logic [2:0]  level_a;
  logic [15:0] len_a;

  spi_rx_framer #(.DATA_W(8), .FIFO_DEPTH(4), .SPI_MODE(0), .SYNC_STAGES(S)) dut_a (
    .axi_aclk(clk), .axi_areset(rst),
    .spi_clk(lead), .spi_mosi(mosi), .spi_cs(cs),
    .rd_en(rd_en_a), .rd_data(rd_data_a),
    .fifo_empty(empty_a), .fifo_full(full_a), .fifo_level(level_a),
    .overflow(ovf_a), .overflow_clr(ovf_clr_a),
    .package_start_int(start_a), .package_end_int(end_a), .package_len(len_a)
  );

  // One DATA_W=12 DUT per SPI mode, all fed from the same bus
  logic [11:0] rd_data_m [4];
  logic        empty_m   [4];
  logic        full_m    [4];
  logic [4:0]  level_m   [4];
  logic        ovf_m     [4];
  logic        start_m   [4];
  logic        end_m     [4];
  logic [15:0] len_m     [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_mode
      logic sclk_m;
      assign sclk_m = lead ^ (gi >= 2);
      spi_rx_framer #(.DATA_W(12), .FIFO_DEPTH(16), .SPI_MODE(gi), .SYNC_STAGES(S)) dut_m (
        .axi_aclk(clk), .axi_areset(rst),
        .spi_clk(sclk_m), .spi_mosi(mosi), .spi_cs(cs),
        .rd_en(1'b0), .rd_data(rd_data_m[gi]),
        .fifo_empty(empty_m[gi]), .fifo_full(full_m[gi]), .fifo_level(level_m[gi]),
        .overflow(ovf_m[gi]), .overflow_clr(1'b0),
        .package_start_int(start_m[gi]), .package_end_int(end_m[gi]),
        .package_len(len_m[gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int end_cnt = 0;
  int ph = 4;
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    if (start_a) start_cnt++;
    if (end_a)   end_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b);
    mosi = b;
    wait_cyc(ph);
    lead = 1'b1;
    wait_cyc(ph);
    lead = 1'b0;
    wait_cyc(ph);
  endtask

  task automatic send_bits(input logic [63:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) spi_bit(bits[i]);
  endtask

  task automatic cs_open();
    cs = 1'b0;
    wait_cyc(4);
  endtask

  task automatic cs_close();
    wait_cyc(2);
    cs = 1'b1;
    wait_cyc(8);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(8);
  endtask

  task automatic clear_overflow(input string tag);
    ovf_clr_a = 1'b1;
    @(negedge clk);
    ovf_clr_a = 1'b0;
    @(negedge clk);
    check({tag, " overflow_clr"}, ovf_a, 0);
  endtask

  // Pops and compares every word queued in exp_q
  task automatic drain(input string tag);
    logic [7:0] w;
    while (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      check({tag, " not empty"}, empty_a, 0);
      check({tag, " rd_data"}, rd_data_a, w);
      rd_en_a = 1'b1;
      @(negedge clk);
      rd_en_a = 1'b0;
      @(negedge clk);
    end
    check({tag, " empty after drain"}, empty_a, 1);
    check({tag, " level after drain"}, level_a, 0);
  endtask

  // One full packet on the main DUT; exp_q holds the words expected in the FIFO
  task automatic run_packet(input logic [63:0] bits, input int n, input int exp_len,
                            input logic exp_ovf, input string tag);
    int s0;
    int e0;
    s0 = start_cnt;
    e0 = end_cnt;
    cs_open();
    check({tag, " start pulse"}, start_cnt - s0, 1);
    send_bits(bits, n);
    check({tag, " no early end"}, end_cnt - e0, 0);
    cs_close();
    check({tag, " single start"}, start_cnt - s0, 1);
    check({tag, " end pulse"}, end_cnt - e0, 1);
    check({tag, " package_len"}, len_a, exp_len);
    check({tag, " overflow"}, ovf_a, exp_ovf);
    check({tag, " level"}, level_a, exp_q.size());
    check({tag, " full"}, full_a, exp_q.size() == 4);
    $display("packet %s: %0d bits, package_len %0d, level %0d, overflow %0d",
             tag, n, len_a, level_a, ovf_a);
    drain(tag);
    if (exp_ovf) clear_overflow(tag);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [63:0] bits;
    int          nbits;
    int          exp_n;
    logic [31:0] exp_w;   // expected FIFO words, first word in the top byte
    int          exp_len;
    logic        exp_ovf;
  } vec_t;

  vec_t vt[5];

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    logic [63:0] rbits;
    int          rn;
    int          nfull;
    int          rem;
    int          total;
    int          rlen;
    int          s0;
    int          e0;

    vt[0] = '{64'hA53C, 16, 2, 32'hA53C_0000, 2, 1'b0};
    vt[1] = '{64'h1122_3344_5566, 48, 4, 32'h1122_3344, 6, 1'b1};
`ifdef SPI_RX_PARTIAL_FLUSH_EN
    vt[2] = '{64'h7FD, 11, 2, 32'hFFA0_0000, 2, 1'b0};
    vt[3] = '{64'h1, 1, 1, 32'h8000_0000, 1, 1'b0};
`else
    vt[2] = '{64'h7FD, 11, 1, 32'hFF00_0000, 1, 1'b0};
    vt[3] = '{64'h1, 1, 0, 32'h0, 0, 1'b0};
`endif
    vt[4] = '{64'h00, 8, 1, 32'h0000_0000, 1, 1'b0};

    // Reset state
    wait_cyc(3);
    check("reset rd_data", rd_data_a, 0);
    check("reset empty", empty_a, 1);
    check("reset full", full_a, 0);
    check("reset level", level_a, 0);
    check("reset overflow", ovf_a, 0);
    check("reset len", len_a, 0);
    rst = 1'b0;
    wait_cyc(10);

    // Table-driven packets
    for (int i = 0; i < 5; i++) begin
      exp_q.delete();
      for (int k = 0; k < vt[i].exp_n; k++) exp_q.push_back(vt[i].exp_w[31 - 8*k -: 8]);
      run_packet(vt[i].bits, vt[i].nbits, vt[i].exp_len, vt[i].exp_ovf, $sformatf("vec%0d", i));
    end

    // All four SPI modes, DATA_W=12
    do_reset();
    cs_open();
    send_bits(64'hABC_5A3, 24);
    cs_close();
    for (int g = 0; g < 4; g++) begin
      check($sformatf("mode%0d rd_data", g), rd_data_m[g], 12'hABC);
      check($sformatf("mode%0d level", g), level_m[g], 2);
      check($sformatf("mode%0d len", g), len_m[g], 2);
      $display("mode %0d: head 0x%0h level %0d", g, rd_data_m[g], level_m[g]);
    end

    // Reset mid-word with cs low
    do_reset();
    cs_open();
    send_bits(64'hC3_C3C3_C3C3, 40);
    cs_close();
    check("prefill overflow", ovf_a, 1);
    check("prefill len", len_a, 5);
    cs_open();
    send_bits(64'h9, 4);
    @(negedge clk);
    rst = 1'b1;
    wait_cyc(2);
    check("midreset rd_data", rd_data_a, 0);
    check("midreset empty", empty_a, 1);
    check("midreset full", full_a, 0);
    check("midreset level", level_a, 0);
    check("midreset overflow", ovf_a, 0);
    check("midreset start", start_a, 0);
    check("midreset end", end_a, 0);
    check("midreset len", len_a, 0);
    s0 = start_cnt;
    e0 = end_cnt;
    rst = 1'b0;
    send_bits(64'h6, 4);
    wait_cyc(6);
    check("postreset no start", start_cnt - s0, 0);
    check("postreset empty", empty_a, 1);
    cs = 1'b1;
    wait_cyc(8);
    check("postreset no end", end_cnt - e0, 0);
    check("postreset still no start", start_cnt - s0, 0);
    $display("reset mid-word: packet ignored");
    exp_q.delete();
    exp_q.push_back(8'h5A);
    run_packet(64'h5A, 8, 1, 1'b0, "after_reset");

    // FIFO full while a word completes with rd_en in the same cycle
    do_reset();
    cs_open();
    send_bits(64'h0102_0304, 32);
    wait_cyc(4);
    check("prefull level", level_a, 4);
    check("prefull full", full_a, 1);
    send_bits(64'h02, 7);
    mosi = 1'b1;
    wait_cyc(4);
    lead = 1'b1;                 // sampling edge of the fifth word's last bit
    wait_cyc(S + 1);
    check("fullpop head", rd_data_a, 8'h01);
    rd_en_a = 1'b1;              // coincides with the push of word 5
    wait_cyc(1);
    rd_en_a = 1'b0;
    wait_cyc(2);
    check("fullpop level", level_a, 4);
    check("fullpop overflow", ovf_a, 0);
    check("fullpop full", full_a, 1);
    lead = 1'b0;
    wait_cyc(4);
    cs_close();
    check("fullpop len", len_a, 5);
    check("fullpop overflow after end", ovf_a, 0);
    $display("full+pop: level %0d overflow %0d", level_a, ovf_a);
    exp_q.delete();
    for (int k = 2; k <= 5; k++) exp_q.push_back(8'(k));
    drain("fullpop");

    // Randomized packets against a word-list model
    for (int r = 0; r < 20; r++) begin
      ph    = $urandom_range(3, 6);
      rn    = $urandom_range(1, 40);
      rbits = {$urandom(), $urandom()};
      rbits = rbits & ((64'd1 << rn) - 64'd1);
      nfull = rn / 8;
      rem   = rn % 8;
      total = nfull;
      exp_q.delete();
      for (int k = 0; k < nfull; k++) begin
        if (exp_q.size() < 4) exp_q.push_back(8'(rbits >> (rn - 8*(k+1))));
      end
`ifdef SPI_RX_PARTIAL_FLUSH_EN
      if (rem != 0) begin
        total++;
        if (exp_q.size() < 4) exp_q.push_back(8'(rbits << (8 - rem)));
      end
`endif
      rlen = total;
      run_packet(rbits, rn, rlen, total > 4, $sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
